// File: rtl/ofifo_drain_pkg.sv
// rtl/ofifo_drain_pkg.sv - shared state encoding and SRAM strobe levels for the OFIFO drain
package ofifo_drain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    ACC_RD,
    ACC_WR,
    FINISH
  } state_t;

  // psum SRAM strobes are active-low
  localparam logic CEN_ON    = 1'b0;
  localparam logic CEN_OFF   = 1'b1;
  localparam logic WEN_WRITE = 1'b0;
  localparam logic WEN_READ  = 1'b1;

endpackage

// File: rtl/ofifo_drain_lane_add.sv
// rtl/ofifo_drain_lane_add.sv - combinational per-lane wrapping adder over a packed psum row
module psum_lane_add #(
  parameter int col     = 8,
  parameter int psum_bw = 16
) (
  input  logic [col*psum_bw-1:0] a,
  input  logic [col*psum_bw-1:0] b,
  output logic [col*psum_bw-1:0] sum
);

  // lanes are independent: no carry crosses a lane boundary
  for (genvar l = 0; l < col; l++) begin : g_lane
    assign sum[l*psum_bw +: psum_bw] = a[l*psum_bw +: psum_bw] + b[l*psum_bw +: psum_bw];
  end

endmodule

// File: rtl/ofifo_drain.sv
// rtl/ofifo_drain.sv - pops psum rows from the OFIFO and stores or accumulates them into psum SRAM
module ofifo_drain
  import ofifo_drain_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic [addr_bw-1:0]       num_rows,
  input  logic                     acc_en,
  input  logic                     ofifo_o_valid,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [addr_bw-1:0]       sram_addr,
  output logic [col*psum_bw-1:0]   sram_d,
  input  logic [col*psum_bw-1:0]   sram_q,
  output logic                     busy,
  output logic                     done
);

  localparam int row_bw = col * psum_bw;

  state_t              state, state_nx;
  logic [addr_bw-1:0]  base_r, nrows_r, idx, idx_nx, cur_addr;
  logic [addr_bw-1:0]  wr_addr_r, hold_addr;
  logic [row_bw-1:0]   row_r, hold_d, acc_sum;
  logic                wr_pend, pop, rows_left, last_row;

  assign cur_addr  = base_r + idx;
  assign rows_left = (idx != nrows_r);
  assign last_row  = ((idx + addr_bw'(1)) == nrows_r);

  // gating with reset keeps a row from leaving the FIFO in the cycle the drain is being aborted
  assign pop      = reset && ofifo_o_valid && rows_left && (state == STORE || state == ACC_RD);
  assign ofifo_rd = pop;
  assign busy     = (state != IDLE);

  psum_lane_add #(
    .col     (col),
    .psum_bw (psum_bw)
  ) u_lane_add (
    .a   (sram_q),
    .b   (row_r),
    .sum (acc_sum)
  );

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    sram_cen  = CEN_OFF;
    sram_wen  = WEN_READ;
    sram_addr = hold_addr;
    sram_d    = hold_d;

    // store mode writes the row popped in the previous cycle
    if (wr_pend) begin
      sram_cen  = CEN_ON;
      sram_wen  = WEN_WRITE;
      sram_addr = wr_addr_r;
      sram_d    = row_r;
    end

    case (state)
      IDLE: begin
        if (start) begin
          idx_nx = '0;
          if (num_rows == '0) state_nx = FINISH;
          else if (acc_en)    state_nx = ACC_RD;
          else                state_nx = STORE;
        end
      end
      STORE: begin
        if (pop) begin
          idx_nx = idx + addr_bw'(1);
          if (last_row) state_nx = FINISH;
        end
      end
      ACC_RD: begin
        if (pop) begin
          sram_cen  = CEN_ON;
          sram_wen  = WEN_READ;
          sram_addr = cur_addr;
          state_nx  = ACC_WR;
        end
      end
      ACC_WR: begin
        sram_cen  = CEN_ON;
        sram_wen  = WEN_WRITE;
        sram_addr = cur_addr;
        sram_d    = acc_sum;
        idx_nx    = idx + addr_bw'(1);
        state_nx  = last_row ? FINISH : ACC_RD;
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      base_r    <= '0;
      nrows_r   <= '0;
      idx       <= '0;
      row_r     <= '0;
      wr_addr_r <= '0;
      wr_pend   <= 1'b0;
      hold_addr <= '0;
      hold_d    <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      hold_addr <= sram_addr;
      hold_d    <= sram_d;
      done      <= (state == FINISH);
      wr_pend   <= pop && (state == STORE);
      if (pop) begin
        row_r     <= ofifo_out;
        wr_addr_r <= cur_addr;
      end
      if (state == IDLE && start) begin
        base_r  <= base_addr;
        nrows_r <= num_rows;
      end
    end
  end

endmodule

// File: tb/tb_ofifo_drain.sv
// tb/tb_ofifo_drain.sv - self-checking bench for ofifo_drain with OFIFO and psum SRAM models
module tb_ofifo_drain;

  localparam int COL = 8;
  localparam int PB  = 16;
  localparam int AB  = 11;
  localparam int RW  = COL * PB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          acc_en = 1'b0;
  logic          vgate = 1'b0;
  logic [AB-1:0] base_addr = '0;
  logic [AB-1:0] num_rows = '0;
  logic          ofifo_o_valid, ofifo_rd, sram_cen, sram_wen, busy, done;
  logic [RW-1:0] ofifo_out, sram_d, sram_q;
  logic [AB-1:0] sram_addr;

  always #5 clk = ~clk;

  ofifo_drain #(.col(COL), .psum_bw(PB), .addr_bw(AB)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .num_rows      (num_rows),
    .acc_en        (acc_en),
    .ofifo_o_valid (ofifo_o_valid),
    .ofifo_out     (ofifo_out),
    .ofifo_rd      (ofifo_rd),
    .sram_cen      (sram_cen),
    .sram_wen      (sram_wen),
    .sram_addr     (sram_addr),
    .sram_d        (sram_d),
    .sram_q        (sram_q),
    .busy          (busy),
    .done          (done)
  );

  // OFIFO model: rows appended by the stimulus, head advanced on each pop
  logic [RW-1:0] fifo_mem [0:1023];
  logic [9:0]    head = '0;
  logic [9:0]    tail = '0;
  assign ofifo_o_valid = vgate && (head != tail);
  assign ofifo_out     = fifo_mem[head];

  // psum SRAM model with a backdoor port, plus event logs
  logic [RW-1:0] mem [0:2047];
  logic [RW-1:0] q_r = '0;
  logic          bd_en = 1'b0;
  logic [AB-1:0] bd_addr = '0;
  logic [RW-1:0] bd_data = '0;
  logic [AB-1:0] wr_log_addr [0:1023];
  logic [RW-1:0] wr_log_data [0:1023];
  logic [AB-1:0] last_rd_addr = '0;
  int n_wr = 0, n_rd = 0, n_pop = 0, n_done = 0;
  assign sram_q = q_r;

  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    if (!sram_cen && !sram_wen) begin
      mem[sram_addr] <= sram_d;
      wr_log_addr[n_wr[9:0]] <= sram_addr;
      wr_log_data[n_wr[9:0]] <= sram_d;
      n_wr <= n_wr + 1;
    end
    if (!sram_cen && sram_wen) begin
      q_r          <= mem[sram_addr];
      last_rd_addr <= sram_addr;
      n_rd         <= n_rd + 1;
    end
    if (ofifo_rd) begin
      head  <= head + 10'd1;
      n_pop <= n_pop + 1;
    end
    if (done) n_done <= n_done + 1;
  end

  logic [RW-1:0] ref_mem [0:2047];
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [PB-1:0] stored;
    logic [PB-1:0] addend;
    logic [PB-1:0] exp_sum;
  } acc_vec_t;
  acc_vec_t tbl [4];

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] add_rows(input logic [RW-1:0] a, input logic [RW-1:0] b);
    logic [RW-1:0] r;
    logic [31:0]   s;
    r = '0;
    for (int l = 0; l < COL; l++) begin
      s = 32'(a[l*PB +: PB]) + 32'(b[l*PB +: PB]);
      r[l*PB +: PB] = 16'(s % 32'd65536);
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_row(input logic [RW-1:0] r);
    fifo_mem[tail] = r;
    tail = tail + 10'd1;
  endtask

  task automatic bd_write(input logic [AB-1:0] a, input logic [RW-1:0] d);
    bd_en = 1'b1;
    bd_addr = a;
    bd_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic kick(input logic [AB-1:0] b, input logic [AB-1:0] n, input logic a);
    start = 1'b1;
    base_addr = b;
    num_rows = n;
    acc_en = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input bit rnd, output int cyc);
    cyc = 0;
    for (int c = 1; c <= maxc; c++) begin
      if (done) begin
        cyc = c;
        break;
      end
      if (rnd) vgate = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    if (cyc == 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within %0d cycles", maxc);
    end
  endtask

  // reference: rows land at base+i (mod 2^AB), stored or added lane-wise to the old contents
  task automatic run_model_drain(input logic [AB-1:0] b, input int n, input logic a, input bit rnd);
    logic [RW-1:0] rows [0:15];
    logic [AB-1:0] ad;
    int p0, w0, r0, d0, cyc;
    for (int i = 0; i < n; i++) begin
      ad = b + i[AB-1:0];
      bd_write(ad, rand_row());
      rows[i] = rand_row();
      push_row(rows[i]);
    end
    p0 = n_pop; w0 = n_wr; r0 = n_rd; d0 = n_done;
    vgate = 1'b1;
    kick(b, n[AB-1:0], a);
    wait_done(400, rnd, cyc);
    vgate = 1'b1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      ad = b + i[AB-1:0];
      ref_mem[ad] = a ? add_rows(ref_mem[ad], rows[i]) : rows[i];
      check("model_mem", mem[ad], ref_mem[ad]);
    end
    check("model_pops", RW'(n_pop - p0), RW'(n));
    check("model_writes", RW'(n_wr - w0), RW'(n));
    check("model_reads", RW'(n_rd - r0), a ? RW'(n) : RW'(0));
    check("model_done", RW'(n_done - d0), RW'(1));
  endtask

  initial begin
    logic [RW-1:0] r4 [0:4];
    logic [RW-1:0] xrow;
    int p0, w0, r0, d0, cyc;
    bit seen;

    tbl[0] = '{16'h0005, 16'h0003, 16'h0008};
    tbl[1] = '{16'h7FFF, 16'h0001, 16'h8000};
    tbl[2] = '{16'hFFFF, 16'h0002, 16'h0001};
    tbl[3] = '{16'h8000, 16'h8000, 16'h0000};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_rd", RW'(ofifo_rd), RW'(0));
    check("rst_cen", RW'(sram_cen), RW'(1));
    check("rst_wen", RW'(sram_wen), RW'(1));
    check("rst_addr", RW'(sram_addr), RW'(0));
    check("rst_d", sram_d, '0);
    check("rst_busy", RW'(busy), RW'(0));
    check("rst_done", RW'(done), RW'(0));
    reset = 1'b1;
    @(negedge clk);

    // store, continuous, cycle-accurate
    for (int i = 0; i < 4; i++) begin
      r4[i] = rand_row();
      push_row(r4[i]);
    end
    vgate = 1'b1;
    r0 = n_rd;
    start = 1'b1; base_addr = 11'h010; num_rows = 11'd4; acc_en = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      check("st_rd", RW'(ofifo_rd), RW'(k <= 4));
      check("st_cen", RW'(sram_cen), RW'(!(k >= 2 && k <= 5)));
      if (k >= 2 && k <= 5) begin
        check("st_wen", RW'(sram_wen), RW'(0));
        check("st_addr", RW'(sram_addr), RW'(11'h010 + 11'(k - 2)));
        check("st_d", sram_d, r4[k-2]);
      end
      check("st_busy", RW'(busy), RW'(k <= 5));
      check("st_done", RW'(done), RW'(k == 6));
    end
    check("st_reads", RW'(n_rd - r0), RW'(0));

    // accumulate table, including lane wrap
    for (int v = 0; v < 4; v++) begin
      bd_write(11'h020, {COL{tbl[v].stored}});
      push_row({COL{tbl[v].addend}});
      w0 = n_wr; r0 = n_rd; d0 = n_done;
      kick(11'h020, 11'd1, 1'b1);
      wait_done(20, 1'b0, cyc);
      @(negedge clk);
      check("acc_mem", mem[11'h020], {COL{tbl[v].exp_sum}});
      check("acc_rd_addr", RW'(last_rd_addr), RW'(11'h020));
      check("acc_wr_addr", RW'(wr_log_addr[w0[9:0]]), RW'(11'h020));
      check("acc_nrd", RW'(n_rd - r0), RW'(1));
      check("acc_nwr", RW'(n_wr - w0), RW'(1));
      check("acc_done", RW'(n_done - d0), RW'(1));
    end

    // store with address wrap at the top of the SRAM
    w0 = n_wr;
    for (int i = 0; i < 3; i++) push_row(rand_row());
    kick(11'h7FE, 11'd3, 1'b0);
    wait_done(20, 1'b0, cyc);
    @(negedge clk);
    check("wrap_a0", RW'(wr_log_addr[w0[9:0]]), RW'(11'h7FE));
    check("wrap_a1", RW'(wr_log_addr[w0[9:0] + 10'd1]), RW'(11'h7FF));
    check("wrap_a2", RW'(wr_log_addr[w0[9:0] + 10'd2]), RW'(11'h000));

    // stall: valid 1,0,0,1,1
    for (int i = 0; i < 3; i++) begin
      r4[i] = rand_row();
      push_row(r4[i]);
    end
    vgate = 1'b0;
    p0 = n_pop; w0 = n_wr;
    kick(11'h300, 11'd3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      vgate = (k == 0 || k >= 3);
      @(negedge clk);
      if (k == 2) check("stall_idle_cen", RW'(sram_cen), RW'(1));
    end
    vgate = 1'b1;
    wait_done(20, 1'b0, cyc);
    @(negedge clk);
    check("stall_pops", RW'(n_pop - p0), RW'(3));
    check("stall_writes", RW'(n_wr - w0), RW'(3));
    for (int i = 0; i < 3; i++) begin
      check("stall_addr", RW'(wr_log_addr[w0[9:0] + i[9:0]]), RW'(11'h300 + i[AB-1:0]));
      check("stall_data", wr_log_data[w0[9:0] + i[9:0]], r4[i]);
    end

    // num_rows == 0 with a row waiting in the FIFO
    xrow = rand_row();
    push_row(xrow);
    vgate = 1'b1;
    p0 = n_pop; w0 = n_wr; r0 = n_rd;
    kick(11'h600, 11'd0, 1'b0);
    wait_done(20, 1'b0, cyc);
    check("zero_done_lat", RW'(cyc), RW'(2));
    @(negedge clk);
    check("zero_pops", RW'(n_pop - p0), RW'(0));
    check("zero_access", RW'((n_wr - w0) + (n_rd - r0)), RW'(0));
    kick(11'h640, 11'd1, 1'b0);
    wait_done(20, 1'b0, cyc);
    @(negedge clk);
    check("zero_after", mem[11'h640], xrow);

    // start while busy is ignored
    for (int i = 0; i < 3; i++) push_row(rand_row());
    vgate = 1'b0;
    p0 = n_pop; w0 = n_wr; d0 = n_done;
    kick(11'h100, 11'd3, 1'b0);
    check("busy_up", RW'(busy), RW'(1));
    kick(11'h200, 11'd7, 1'b1);
    vgate = 1'b1;
    wait_done(40, 1'b0, cyc);
    repeat (3) @(negedge clk);
    check("ign_pops", RW'(n_pop - p0), RW'(3));
    check("ign_writes", RW'(n_wr - w0), RW'(3));
    check("ign_last_addr", RW'(wr_log_addr[w0[9:0] + 10'd2]), RW'(11'h102));
    check("ign_done", RW'(n_done - d0), RW'(1));
    check("ign_busy", RW'(busy), RW'(0));

    // reset after the second of five rows
    for (int i = 0; i < 5; i++) begin
      r4[i] = rand_row();
      push_row(r4[i]);
    end
    p0 = n_pop;
    kick(11'h400, 11'd5, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (n_pop - p0 == 2) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rmd_two_pops", RW'(seen), RW'(1));
    reset = 1'b0;
    @(negedge clk);
    check("rmd_rd", RW'(ofifo_rd), RW'(0));
    check("rmd_cen", RW'(sram_cen), RW'(1));
    check("rmd_wen", RW'(sram_wen), RW'(1));
    check("rmd_addr", RW'(sram_addr), RW'(0));
    check("rmd_d", sram_d, '0);
    check("rmd_busy", RW'(busy), RW'(0));
    check("rmd_done", RW'(done), RW'(0));
    check("rmd_pops", RW'(n_pop - p0), RW'(2));
    reset = 1'b1;
    @(negedge clk);
    kick(11'h500, 11'd3, 1'b0);
    wait_done(20, 1'b0, cyc);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      check("rmd_redrain", mem[11'h500 + i[AB-1:0]], r4[i+2]);
    check("rmd_total_pops", RW'(n_pop - p0), RW'(5));

    // randomized drains against the reference model
    for (int t = 0; t < 30; t++)
      run_model_drain(11'($urandom_range(0, 2047)), int'($urandom_range(1, 6)),
                      1'($urandom_range(0, 1)), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
